// File: rtl/sn74ls595_driver.sv
// Serialises a parallel word onto a chain of cascaded sn74ls595 parts and
// drives their shift clock, register clock, clear and output enable pins.
module sn74ls595_driver #(
    parameter int NBYTES = 1,
    parameter int DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NBYTES-1:0]   data,
    input  logic                  start,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  ser,
    output logic                  sck,
    output logic                  rck,
    output logic                  sclr,
    output logic                  g,
    output logic [2:0]            fsm_state
);
    localparam int NBITS = 8 * NBYTES;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW    = $clog2(NBITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        LATCH = 3'd3,
        CLR   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Handshake: start/clear are sampled only while busy=0 (IDLE) and are
    // dropped, not queued, otherwise; busy rises on the accepting edge and
    // done pulses for exactly one cycle in the final busy cycle.
    state_t           state;
    logic [NBITS-2:0] shadow;     // bits still to be sent after the one on ser
    logic [BW-1:0]    bitcnt;
    logic [DW-1:0]    divcnt;
    logic             phase_end;

    assign phase_end = (divcnt == DIV_LAST);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            bitcnt <= '0;
            divcnt <= '0;
            ser    <= 1'b0;
            sck    <= 1'b0;
            rck    <= 1'b0;
            sclr   <= 1'b0;
            g      <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sck    <= 1'b0;
                    rck    <= 1'b0;
                    sclr   <= 1'b1;
                    done   <= 1'b0;
                    divcnt <= '0;
                    if (clear) begin
                        state <= CLR;
                        sclr  <= 1'b0;
                        ser   <= 1'b0;
                        busy  <= 1'b1;
                    end else if (start) begin
                        state  <= LOW;
                        shadow <= data[NBITS-2:0];
                        ser    <= data[NBITS-1];
                        bitcnt <= BW'(NBITS);
                        busy   <= 1'b1;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        divcnt <= '0;
                        sck    <= 1'b1;
                        state  <= HIGH;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        divcnt <= '0;
                        sck    <= 1'b0;
                        bitcnt <= bitcnt - 1'b1;
                        if (bitcnt == BW'(1)) begin
                            state <= LATCH;
                            rck   <= 1'b1;
                            ser   <= 1'b0;
                        end else begin
                            state  <= LOW;
                            ser    <= shadow[NBITS-2];
                            shadow <= {shadow[NBITS-3:0], 1'b0};
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                CLR: begin
                    // Shift registers are already zero; the LATCH pulse copies them to q.
                    if (phase_end) begin
                        divcnt <= '0;
                        sclr   <= 1'b1;
                        rck    <= 1'b1;
                        state  <= LATCH;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        divcnt <= '0;
                        rck    <= 1'b0;
                        done   <= 1'b1;
                        g      <= 1'b0;
                        state  <= DONE;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn74ls595_driver.sv
// Bench for sn74ls595_driver: one single-device and one two-device chain,
// each feeding a behavioural model of the attached sn74ls595 parts.
module tb_sn74ls595_driver;
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, clear_a = 1'b0;
    logic [7:0]  data_a  = '0;
    logic        busy_a, done_a, ser_a, sck_a, rck_a, sclr_a, g_a;
    logic [2:0]  st_a;
    logic        start_b = 1'b0, clear_b = 1'b0;
    logic [15:0] data_b  = '0;
    logic        busy_b, done_b, ser_b, sck_b, rck_b, sclr_b, g_b;
    logic [2:0]  st_b;

    sn74ls595_driver #(.NBYTES(1), .DIV(DIV)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .start(start_a), .clear(clear_a),
        .busy(busy_a), .done(done_a), .ser(ser_a), .sck(sck_a), .rck(rck_a),
        .sclr(sclr_a), .g(g_a), .fsm_state(st_a)
    );

    sn74ls595_driver #(.NBYTES(2), .DIV(DIV)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .start(start_b), .clear(clear_b),
        .busy(busy_b), .done(done_b), .ser(ser_b), .sck(sck_b), .rck(rck_b),
        .sclr(sclr_b), .g(g_b), .fsm_state(st_b)
    );

    // Attached 595 chains: async clear, shift on sck rise, latch on rck rise.
    logic [7:0]  sr_a, q_a;
    logic [15:0] sr_b, q_b;
    always @(posedge sck_a or negedge sclr_a)
        if (!sclr_a) sr_a <= '0; else sr_a <= {sr_a[6:0], ser_a};
    always @(posedge rck_a) q_a <= sr_a;
    always @(posedge sck_b or negedge sclr_b)
        if (!sclr_b) sr_b <= '0; else sr_b <= {sr_b[14:0], ser_b};
    always @(posedge rck_b) q_b <= sr_b;

    logic [0:0] seen_a[$];
    logic [0:0] seen_b[$];
    logic [0:0] exp_q[$];
    always @(posedge sck_a) seen_a.push_back(ser_a);
    always @(posedge sck_b) seen_b.push_back(ser_b);

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic busy, done, ser, sck, rck, sclr, g;
    } pins_t;
    localparam pins_t RST_PINS = 7'b0000001;

    function automatic pins_t pins(input int dev);
        pins_t p;
        if (dev == 0) p = {busy_a, done_a, ser_a, sck_a, rck_a, sclr_a, g_a};
        else          p = {busy_b, done_b, ser_b, sck_b, rck_b, sclr_b, g_b};
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int dev, input logic s, input logic c, input logic [15:0] d);
        if (dev == 0) begin start_a = s; clear_a = c; data_a = d[7:0]; end
        else          begin start_b = s; clear_b = c; data_b = d;      end
    endtask

    // One transfer; optional start pulse with other data at cycle inj_cyc.
    task automatic run_xfer(input string tag, input int dev, input logic [15:0] word,
                            input int inj_cyc, input logic [15:0] inj_word);
        int nbits, exp_len, cyc, busy_n, done_n, done_at, rck_n, rck_rise;
        logic prev_rck;
        logic [15:0] got_w, exp_w;
        logic [0:0] got_q[$];
        pins_t p;
        nbits   = (dev == 0) ? 8 : 16;
        exp_len = nbits * 2 * DIV + DIV + 1;
        busy_n = 0; done_n = 0; done_at = -1; rck_n = 0; rck_rise = 0; prev_rck = 1'b0;
        exp_q.delete();
        for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(word[i]);
        seen_a.delete(); seen_b.delete();
        @(negedge clk); drive(dev, 1'b1, 1'b0, word);
        @(negedge clk); drive(dev, 1'b0, 1'b0, 16'($urandom));
        cyc = 1;
        while (cyc <= exp_len + 10) begin
            p = pins(dev);
            if (!p.busy) break;
            busy_n++;
            if (p.done) begin done_n++; done_at = cyc; end
            if (p.rck) rck_n++;
            if (p.rck && !prev_rck) rck_rise++;
            prev_rck = p.rck;
            if (cyc == inj_cyc) drive(dev, 1'b1, 1'b0, inj_word);
            else                drive(dev, 1'b0, 1'b0, 16'($urandom));
            @(negedge clk); cyc++;
        end
        drive(dev, 1'b0, 1'b0, 16'($urandom));
        got_q = (dev == 0) ? seen_a : seen_b;
        check({tag, "_busy_len"}, busy_n, exp_len);
        check({tag, "_done_cnt"}, done_n, 1);
        check({tag, "_done_at"}, done_at, exp_len);
        check({tag, "_rck_pulses"}, rck_rise, 1);
        check({tag, "_rck_width"}, rck_n, DIV);
        check({tag, "_sck_rises"}, got_q.size(), nbits);
        got_w = '0; exp_w = '0;
        while (exp_q.size() > 0) begin
            exp_w = {exp_w[14:0], exp_q.pop_front()};
            got_w = {got_w[14:0], (got_q.size() > 0) ? got_q.pop_front() : 1'bx};
        end
        check({tag, "_ser_bits"}, got_w, exp_w);
        check({tag, "_g_low"}, pins(dev).g, 1'b0);
        if (dev == 0) begin
            check({tag, "_q"}, q_a, word[7:0]);
        end else begin
            check({tag, "_q_near"}, q_b[7:0], word[7:0]);
            check({tag, "_q_far"}, q_b[15:8], word[15:8]);
        end
    endtask

    // clear and start raised together; clear must win.
    task automatic run_clear(input string tag, input int dev);
        int cyc, busy_n, done_at, sclr_lo, ser_hi, rck_rise;
        logic prev_rck;
        pins_t p;
        busy_n = 0; done_at = -1; sclr_lo = 0; ser_hi = 0; rck_rise = 0; prev_rck = 1'b0;
        seen_a.delete(); seen_b.delete();
        @(negedge clk); drive(dev, 1'b1, 1'b1, 16'($urandom));
        @(negedge clk); drive(dev, 1'b0, 1'b0, 16'($urandom));
        cyc = 1;
        while (cyc <= 30) begin
            p = pins(dev);
            if (!p.busy) break;
            busy_n++;
            if (p.done) done_at = cyc;
            if (!p.sclr) sclr_lo++;
            if (p.ser) ser_hi++;
            if (p.rck && !prev_rck) rck_rise++;
            prev_rck = p.rck;
            @(negedge clk); cyc++;
        end
        check({tag, "_busy_len"}, busy_n, 2 * DIV + 1);
        check({tag, "_done_at"}, done_at, 2 * DIV + 1);
        check({tag, "_sclr_low"}, sclr_lo, DIV);
        check({tag, "_ser_high"}, ser_hi, 0);
        check({tag, "_rck_pulses"}, rck_rise, 1);
        check({tag, "_sck_rises"}, (dev == 0) ? seen_a.size() : seen_b.size(), 0);
        check({tag, "_q_zero"}, (dev == 0) ? 32'(q_a) : 32'(q_b), 0);
    endtask

    initial begin
        int cyc;
        logic [7:0] w;
        n_cmp = 0;
        n_fail = 0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1 check("rst_pins_a", pins(0), RST_PINS);
        check("rst_pins_b", pins(1), RST_PINS);
        @(negedge clk); rst = 1'b0;
        #1 check("sclr_held", sclr_a, 1'b0);
        @(posedge clk); #1 check("sclr_release", sclr_a, 1'b1);
        check("idle_busy", busy_a, 1'b0);

        run_xfer("a5", 0, 16'h00A5, -1, 16'h0);
        run_xfer("x1234", 1, 16'h1234, -1, 16'h0);
        run_xfer("ignored", 0, 16'h000F, 5, 16'h00FF);
        run_clear("clr_a", 0);
        run_clear("clr_b", 1);

        for (int i = 0; i < 3; i++) begin
            run_xfer("rnd_a", 0, 16'($urandom_range(0, 255)), -1, 16'h0);
            run_xfer("rnd_b", 1, 16'($urandom), -1, 16'h0);
        end

        // start held high: next accept in the first IDLE cycle after DONE.
        w = 8'($urandom);
        @(negedge clk); drive(0, 1'b1, 1'b0, {8'h00, w});
        cyc = 0;
        while (!done_a && cyc < 100) begin @(negedge clk); cyc++; end
        check("hold_done_seen", done_a, 1'b1);
        @(negedge clk); check("hold_idle_gap", busy_a, 1'b0);
        @(negedge clk); check("hold_reaccept", busy_a, 1'b1);
        drive(0, 1'b0, 1'b0, 16'h0);
        cyc = 0;
        while (busy_a && cyc < 100) begin @(negedge clk); cyc++; end
        check("hold_finish", busy_a, 1'b0);
        check("hold_q", q_a, w);

        // Reset during the third HIGH phase, then a clean transfer.
        seen_a.delete();
        @(negedge clk); drive(0, 1'b1, 1'b0, 16'($urandom));
        @(negedge clk); drive(0, 1'b0, 1'b0, 16'h0);
        cyc = 0;
        while (!(seen_a.size() == 3 && sck_a) && cyc < 100) begin @(negedge clk); cyc++; end
        check("third_high_reached", 32'(seen_a.size()), 3);
        #2 rst = 1'b1;
        #1 check("midrst_pins", pins(0), RST_PINS);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_xfer("after_rst", 0, 16'h003C, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
